// File: rtl/gpioseq.sv
// gpioseq: timed GPIO pattern sequencer, Wishbone slave table in, Wishbone master GPIO writes out.
// Optional feature macro: GPIOSEQ_LOOP_EN (honour the CTRL LOOP bit and read it back at CTRL bit1).
module gpioseq #(
  parameter int LGSTEPS = 3,
  parameter int DW      = 16
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_wb_cyc,
  input  logic               i_wb_stb,
  input  logic               i_wb_we,
  input  logic [LGSTEPS+1:0] i_wb_addr,
  input  logic [31:0]        i_wb_data,
  input  logic [3:0]         i_wb_sel,
  output logic               o_wb_stall,
  output logic               o_wb_ack,
  output logic [31:0]        o_wb_data,
  output logic               o_gp_cyc,
  output logic               o_gp_stb,
  output logic               o_gp_we,
  output logic [31:0]        o_gp_data,
  output logic [3:0]         o_gp_sel,
  input  logic               i_gp_stall,
  input  logic               i_gp_ack,
  input  logic               i_gp_err,
  output logic               o_int
);
  localparam int AW = LGSTEPS + 2;
  localparam int N  = 1 << LGSTEPS;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ACKW, S_DELAY, S_NEXT} state_t;
  state_t               r_state, w_next;
  logic [31:0]          r_cmd [N];
  logic [DW-1:0]        r_dly [N];
  logic [LGSTEPS-1:0]   r_step, r_last;
  logic [DW-1:0]        r_cnt;
  logic                 r_done, r_err, r_int, r_wb_ack;
  logic [31:0]          r_wb_data, w_rdata;
  logic                 w_stb, w_wr, w_ctrl_wr, w_abort, w_start, w_busy, w_at_last, w_loop, w_fin, w_fail;
  logic [LGSTEPS-1:0]   w_idx;
  logic                 w_unused;
`ifdef GPIOSEQ_LOOP_EN
  logic                 r_loop;
  assign w_loop = r_loop;
`else
  assign w_loop = 1'b0;
`endif
  assign w_unused   = &{1'b0, i_wb_sel};
  assign w_stb      = i_wb_cyc & i_wb_stb;
  assign w_wr       = w_stb & i_wb_we;
  assign w_ctrl_wr  = w_wr && (i_wb_addr == AW'(0));
  assign w_abort    = w_ctrl_wr & i_wb_data[2];
  assign w_busy     = r_state != S_IDLE;
  assign w_start    = w_ctrl_wr & i_wb_data[0] & ~w_busy & ~w_abort;
  assign w_idx      = i_wb_addr[LGSTEPS:1];
  assign w_at_last  = r_step == r_last;
  assign w_fin      = (r_state == S_NEXT) & w_at_last & ~w_loop & ~w_abort;
  assign w_fail     = (r_state == S_ACKW) & i_gp_err & ~w_abort;
  assign o_wb_stall = 1'b0;
  assign o_wb_ack   = r_wb_ack;
  assign o_wb_data  = r_wb_data;
  assign o_gp_cyc   = (r_state == S_ISSUE) | (r_state == S_ACKW);
  assign o_gp_stb   = r_state == S_ISSUE;
  assign o_gp_we    = 1'b1;
  assign o_gp_sel   = 4'hf;
  assign o_gp_data  = r_cmd[r_step];
  assign o_int      = r_int;
  // Next-state: abort overrides everything; err takes priority over a simultaneous ack.
  always_comb begin
    w_next = r_state;
    if (w_abort) w_next = S_IDLE;
    else
      case (r_state)
        S_IDLE:  w_next = w_start ? S_ISSUE : S_IDLE;
        S_ISSUE: w_next = i_gp_stall ? S_ISSUE : S_ACKW;
        S_ACKW:  w_next = i_gp_err ? S_IDLE : i_gp_ack ? ((r_dly[r_step] != '0) ? S_DELAY : S_NEXT) : S_ACKW;
        S_DELAY: w_next = (r_cnt == DW'(1)) ? S_NEXT : S_DELAY;
        S_NEXT:  w_next = (!w_at_last || w_loop) ? S_ISSUE : S_IDLE;
        default: w_next = S_IDLE;
      endcase
  end
  // Read mux for the slave port.
  always_comb begin
    w_rdata = '0;
    if (i_wb_addr[AW-1]) w_rdata = i_wb_addr[0] ? 32'(r_dly[w_idx]) : r_cmd[w_idx];
    else if (i_wb_addr == AW'(0)) begin
      w_rdata[8 +: LGSTEPS] = r_last;
`ifdef GPIOSEQ_LOOP_EN
      w_rdata[1] = r_loop;
`endif
    end else if (i_wb_addr == AW'(1)) begin
      w_rdata[8 +: LGSTEPS] = r_step;
      w_rdata[2:0] = {r_err, r_done, w_busy};
    end
  end
  // Sequencer state, step pointer, delay counter and sticky status.
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_last  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_int   <= 1'b0;
`ifdef GPIOSEQ_LOOP_EN
      r_loop  <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_int   <= w_fin | w_fail;
      r_done  <= w_fin | (r_done & ~w_wr);
      r_err   <= w_fail | (r_err & ~w_wr);
      if (w_start) begin
        r_step <= '0;
        r_last <= i_wb_data[8 +: LGSTEPS];
`ifdef GPIOSEQ_LOOP_EN
        r_loop <= i_wb_data[1];
`endif
      end else if (r_state == S_NEXT && (!w_at_last || w_loop))
        r_step <= w_at_last ? '0 : r_step + LGSTEPS'(1);
      if (r_state == S_ACKW) r_cnt <= r_dly[r_step];
      else if (r_state == S_DELAY) r_cnt <= r_cnt - DW'(1);
    end
  // Step table; writes during playback are dropped so the running sequence is stable.
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      for (int i = 0; i < N; i++) begin
        r_cmd[i] <= '0;
        r_dly[i] <= '0;
      end
    end else if (w_wr && i_wb_addr[AW-1] && !w_busy) begin
      if (i_wb_addr[0]) r_dly[w_idx] <= i_wb_data[DW-1:0];
      else r_cmd[w_idx] <= i_wb_data;
    end
  // Slave acknowledge and registered read data.
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_wb_ack  <= 1'b0;
      r_wb_data <= '0;
    end else begin
      r_wb_ack <= w_stb;
      if (w_stb && !i_wb_we) r_wb_data <= w_rdata;
    end
endmodule
